// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port unified memory between the fetch (IF) and data (D) ports.
// Optional build macro ARB_ROUND_ROBIN_EN: strict alternation on contention instead of D priority + starvation counter.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      if_req,
    input  logic [ADDR_WIDTH-1:0]     if_addr,
    output logic [DATA_WIDTH-1:0]     if_rdata,
    output logic                      if_valid,
    output logic                      if_stall,
    input  logic                      d_req,
    input  logic                      d_we,
    input  logic [ADDR_WIDTH-1:0]     d_addr,
    input  logic [DATA_WIDTH-1:0]     d_wdata,
    input  logic [DATA_WIDTH/8-1:0]   d_be,
    output logic [DATA_WIDTH-1:0]     d_rdata,
    output logic                      d_valid,
    output logic                      d_stall,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [DATA_WIDTH/8-1:0]   mem_be,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      busy
);

    localparam int unsigned BE_W   = DATA_WIDTH / 8;
    localparam int unsigned WCNT_W = 3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_owner_if;
    logic                  r_req_we;
    logic [WCNT_W-1:0]     r_wait_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic [BE_W-1:0]       r_mem_be;
    logic [DATA_WIDTH-1:0] r_if_rdata;
    logic [DATA_WIDTH-1:0] r_d_rdata;
    logic                  r_if_valid;
    logic                  r_d_valid;
    logic                  r_busy;
    logic                  w_any_req;
    logic                  w_grant_if;
    logic                  w_last_wait;

    assign w_any_req   = if_req | d_req;
    assign w_last_wait = (r_wait_cnt == WCNT_W'(1));

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_if;

    // Contention goes to whichever port did not win the previous grant.
    assign w_grant_if = if_req & (~d_req | ~r_last_if);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_last_if <= 1'b1;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_if <= w_grant_if;
        end
    end
`else
    localparam int unsigned SCNT_W = 4;

    logic [SCNT_W-1:0] r_starve_cnt;
    logic              w_starved;

    assign w_starved  = (r_starve_cnt == SCNT_W'(STARVE_LIMIT));
    assign w_grant_if = if_req & (~d_req | w_starved);

    // Counts D grants taken while fetch waits; saturates so fetch is forced through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_starve_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            if (!if_req || w_grant_if) begin
                r_starve_cnt <= '0;
            end else if (!w_starved) begin
                r_starve_cnt <= r_starve_cnt + SCNT_W'(1);
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_state_nxt = S_ACCESS;
            S_ACCESS: w_state_nxt = r_req_we ? S_RESP : S_WAIT;
            S_WAIT:   if (w_last_wait) w_state_nxt = S_RESP;
            S_RESP:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Request capture, memory strobe, read-data capture and response pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_owner_if  <= 1'b0;
            r_req_we    <= 1'b0;
            r_wait_cnt  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
            r_if_valid  <= (w_state_nxt == S_RESP) & r_owner_if;
            r_d_valid   <= (w_state_nxt == S_RESP) & ~r_owner_if;
            r_busy      <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner_if  <= w_grant_if;
                        r_req_we    <= ~w_grant_if & d_we;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= ~w_grant_if & d_we;
                        r_mem_addr  <= w_grant_if ? if_addr : d_addr;
                        r_mem_wdata <= w_grant_if ? '0 : d_wdata;
                        r_mem_be    <= w_grant_if ? '0 : d_be;
                    end
                end
                S_ACCESS: r_wait_cnt <= WCNT_W'(MEM_LATENCY);
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - WCNT_W'(1);
                    if (w_last_wait) begin
                        if (r_owner_if) begin
                            r_if_rdata <= mem_rdata;
                        end else begin
                            r_d_rdata <= mem_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_be    = r_mem_be;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign if_valid  = r_if_valid;
    assign d_valid   = r_d_valid;
    assign busy      = r_busy;
    assign if_stall  = if_req & ~r_if_valid;
    assign d_stall   = d_req & ~r_d_valid;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port unified instruction/data memory between two requesters: the fetch stage (IF port) and the MEM stage (D port).
- Sequences every access through a registered FSM: accept, issue, wait for fixed memory latency, respond.
- Drives per-port stall outputs, which the top level ORs into the hazard unit's stallF and into a whole-pipeline stall for the MEM stage.
- Data port has priority. A starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_WIDTH, 32, address width of all ports.
DATA_WIDTH, 32, data width of all ports.
MEM_LATENCY, 2, cycles from mem_en high to mem_rdata valid; legal range 1..7.
STARVE_LIMIT, 4, consecutive D grants while if_req is pending before IF is forced to win; legal range 1..15.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, synchronous, active-low.
if_req  in  1  fetch read request; held with if_addr stable until if_valid.
if_addr  in  ADDR_WIDTH  fetch address.
if_rdata  out  DATA_WIDTH  fetch read data; registered; holds until the next IF read completes.
if_valid  out  1  one-cycle pulse: IF access complete.
if_stall  out  1  if_req & ~if_valid (combinational).
d_req  in  1  data request; held with all d_* inputs stable until d_valid.
d_we  in  1  1 = write, 0 = read.
d_addr  in  ADDR_WIDTH  data address.
d_wdata  in  DATA_WIDTH  store data.
d_be  in  DATA_WIDTH/8  byte enables for writes.
d_rdata  out  DATA_WIDTH  load data; registered; holds until the next D read completes.
d_valid  out  1  one-cycle pulse: D access complete.
d_stall  out  1  d_req & ~d_valid (combinational).
mem_en  out  1  memory access strobe, one cycle per access.
mem_we  out  1  memory write enable.
mem_addr  out  ADDR_WIDTH  memory address.
mem_wdata  out  DATA_WIDTH  memory write data.
mem_be  out  DATA_WIDTH/8  memory byte enables.
mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LATENCY cycles after mem_en.
busy  out  1  state != IDLE.

Behaviour:
- Reset (rst == 0 at a clock edge):
  - state = IDLE; owner = D; starve_cnt = 0; wait_cnt = 0.
  - All mem_* outputs = 0; if_valid = d_valid = 0; if_rdata = d_rdata = 0.
  - Reset mid-access drops the outstanding access; no valid pulse is produced for it.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Samples requests. If any is pending, latch winner into owner, and latch addr/we/wdata/be into request registers.
  - No request: stay in IDLE.
- Arbitration in IDLE:
  - Only one requester pending: it wins.
  - Both pending: D wins, unless starve_cnt == STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on each D grant while if_req is high. It clears on any IF grant, or on an idle cycle with if_req low. It saturates at STARVE_LIMIT.
- ACCESS (1 cycle):
  - mem_en = 1; mem_addr/mem_we/mem_wdata/mem_be driven from the request registers. IF accesses always use mem_we = 0.
  - mem_* outputs are 0 in every other state.
  - Next state: RESP if the access is a write; otherwise WAIT with wait_cnt = MEM_LATENCY.
- WAIT:
  - Decrement wait_cnt each cycle.
  - In the cycle where wait_cnt == 1, register mem_rdata into the owner's rdata register and go to RESP.
- RESP (1 cycle): owner's valid = 1. Next state is IDLE, even if requests are pending.
- Latency, counting the cycle IDLE samples the request as cycle 0:
  - Read: valid at cycle MEM_LATENCY+2 (cycle 4 at the defaults).
  - Write: valid at cycle 2.
  - Back-to-back accesses are separated by at least one IDLE cycle.
- Requester drops req mid-transaction (protocol violation): the access completes and valid still pulses. Sampled inputs are ignored after IDLE.
- Simultaneous valid and a new req on the same port: the new req is sampled in the following IDLE cycle.
- busy is high throughout ACCESS, WAIT and RESP.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: contention is resolved by strict alternation. A last_owner register is reset to IF, so D wins the first contended cycle. The starvation counter is not built and STARVE_LIMIT is ignored.
- Undefined: fixed D priority with the starvation counter, as above.

Test Plan:
- IF read only, MEM_LATENCY=2, mem returns 0x00A00093 for addr 0x0 -> mem_en at cycle 1; if_valid pulse at cycle 4; if_rdata = 0x00A00093; if_stall high in cycles 0-3, low in cycle 4.
- if_req and d_req (read, addr 0x100, mem returns 0xDEADBEEF) both asserted in cycle 0 -> D served first, d_valid at cycle 4 with 0xDEADBEEF; IF mem_en at cycle 6; if_valid at cycle 9.
- D write, addr 0x200, wdata 0x12345678, be 0xF -> cycle 1: mem_en = mem_we = 1 with those values; d_valid at cycle 2; d_rdata unchanged.
- d_req held continuously plus if_req held, STARVE_LIMIT=4 -> exactly 4 D grants, then 1 IF grant, then D again; starve_cnt returns to 0.
- rst driven low during WAIT of a read -> next cycle: state IDLE, busy = 0, no valid pulse, both rdata registers = 0; a fresh request after rst returns high completes normally.
- ARB_ROUND_ROBIN_EN defined, both ports requesting continuously -> grant order D, IF, D, IF, with valid pulses alternating every MEM_LATENCY+3 cycles.
